sobel_kernel_block: RTL and testbench
=====================================

Name: sobel_kernel_block

Overview:
Downstream consumer of the Sobel shift-buffer stage. Each enabled beat accepts four 32-bit row taps (rows A-D), each holding two adjacent 16-bit pixels. The block forms 3x3 windows for two output rows, centred on rows B and C. It computes |Gx|+|Gy| per window through a 3-stage pipeline and emits two saturated gradient magnitudes per beat, plus a valid strobe and a per-line output column count.

Parameters:
PIXW, 16, pixel width in bits; each row tap is 2*PIXW bits.
OUTW, 16, output magnitude width; results saturate to 2^OUTW-1.
COLW, 12, width of the output column counter.
THRESH, 1024, edge threshold; used only when SOBEL_THRESHOLD_EN is defined.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
sobelKernelEn  in  1  beat valid; row taps are sampled when high
lineStart  in  1  qualifies the first beat of an image line; sampled only with sobelKernelEn
sobelShiftOutA  in  2*PIXW  row A tap; [2P-1:P] = column k+1, [P-1:0] = column k+2
sobelShiftOutB  in  2*PIXW  row B tap, same layout
sobelShiftOutC  in  2*PIXW  row C tap, same layout
sobelShiftOutD  in  2*PIXW  row D tap, same layout
magOutB  out  OUTW  gradient magnitude of the window centred on row B
magOutC  out  OUTW  gradient magnitude of the window centred on row C
magValid  out  1  one-cycle strobe; magOutB and magOutC are valid while it is high
colCount  out  COLW  number of magValid strobes since the last lineStart

Behaviour:
- Reset (synchronous, active-high): magOutB=0, magOutC=0, magValid=0, colCount=0. All pipeline valid bits, the primed flag and the column register clear. Reset asserted mid-operation discards in-flight results; no magValid is produced for beats accepted before reset.
- Column register: on each accepted beat it captures the upper pixel of each tap. This value is column k for the next beat.
- Window: on an accepted beat with primed=1, the columns are left = column register, mid = current upper pixels, right = current lower pixels.
- Priming:
  - primed=0 after reset.
  - A beat with lineStart=1 loads the column register, sets primed=1 and produces no output.
  - A beat with primed=0 and lineStart=0 loads the column register, sets primed=1 and produces no output.
  - Every later beat with primed=1 and lineStart=0 produces one output.
- Arithmetic, unsigned PIXW-bit pixels; row r = B or C:
  - Gx = (R[r-1]+2R[r]+R[r+1]) - (L[r-1]+2L[r]+L[r+1]), where R is the right column and L the left column.
  - Gy = (row r+1: left+2mid+right) - (row r-1: left+2mid+right).
  - Gx and Gy are signed, PIXW+3 bits, and never overflow.
  - mag = |Gx|+|Gy|, unsigned PIXW+3 bits, saturated to OUTW bits.
- Pipeline:
  - S1 registers the window and the partial row/column sums.
  - S2 registers Gx and Gy.
  - S3 registers the saturated magnitude and asserts magValid.
  - Latency is exactly 3 clocks from the accepting edge to the edge that raises magValid.
  - The pipeline drains whenever sobelKernelEn is low; no stall input exists.
  - Back-to-back productive beats give back-to-back magValid.
- magOutB and magOutC hold their last value while magValid=0.
- colCount:
  - Increments by 1 on each magValid.
  - A beat with lineStart accepted at edge n clears the count at edge n. If a magValid from the previous line occurs at edge n, the clear wins; a magValid at edge n+1 or later counts toward the new line.
  - Wraps from 2^COLW-1 to 0.
- If lineStart=1 while sobelKernelEn=0, it is ignored.

Optional Feature:
SOBEL_THRESHOLD_EN
- Defined: in S3, each magnitude is replaced by all-ones if it is >= THRESH, else 0. This produces a binary edge map; latency is unchanged.
- Undefined: raw saturated magnitudes are output, and THRESH is unused.

Test Plan:
- Reset and flat image: reset 2 clocks, then 8 beats with all pixels 0x0100, first beat lineStart=1 -> 7 magValid strobes, first 3 clocks after the 2nd beat; every magOut = 0; colCount ends at 7.
- Vertical step: per line, left and mid columns 0, right column 100 on all rows -> magOutB = magOutC = 400 (Gx=400, Gy=0).
- Horizontal step: rows A,B = 0 and rows C,D = 50 on all columns. Window B (rows A-C): Gy=200, magOutB=200. Window C (rows B-D): Gy=(4×50)-(4×0)=200, magOutC=200.
- Saturation: left column 0, right column 0xFFFF, OUTW=16 -> Gx=262140; magOut = 0xFFFF for both rows.
- Gapped input and re-prime:
  - Productive beats separated by 1-3 idle cycles -> magValid always exactly 3 clocks after each productive beat.
  - A lineStart beat mid-stream -> no output for that beat, and colCount clears on that edge.
  - Reset asserted while 2 results are in flight -> those results never appear.
- With SOBEL_THRESHOLD_EN and THRESH=1024: step of 255 gives mag 1020 -> output 0; step of 256 gives mag 1024 -> output 0xFFFF.

Source files
------------

// File: rtl/sobel_kernel_block.sv
// sobel_kernel_block
// Two-row 3x3 Sobel kernel: each beat takes four row taps (A-D), each holding
// two adjacent pixels. Windows centred on rows B and C yield |Gx|+|Gy|,
// saturated to OUTW bits. magValid follows the accepting edge by three clocks.
// colCount counts strobes since the last lineStart beat.
// Optional build macro: SOBEL_THRESHOLD_EN -- when defined, the output stage
// turns each magnitude into a binary edge flag (all-ones if >= THRESH, else 0).
module sobel_kernel_block #(
    parameter int PIXW   = 16,
    parameter int OUTW   = 16,
    parameter int COLW   = 12,
    parameter int THRESH = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sobelKernelEn,
    input  logic              lineStart,
    input  logic [2*PIXW-1:0] sobelShiftOutA,
    input  logic [2*PIXW-1:0] sobelShiftOutB,
    input  logic [2*PIXW-1:0] sobelShiftOutC,
    input  logic [2*PIXW-1:0] sobelShiftOutD,
    output logic [OUTW-1:0]   magOutB,
    output logic [OUTW-1:0]   magOutC,
    output logic              magValid,
    output logic [COLW-1:0]   colCount
);

    // Weighted sums (a+2b+c) need two extra bits; signed differences need one more.
    localparam int SW = PIXW + 2;
    localparam int MW = PIXW + 3;
    localparam int WW = (MW > OUTW) ? MW : OUTW;

    typedef logic [3:0][PIXW-1:0] col_t;

    localparam col_t              COL_ZERO = {(4*PIXW){1'b0}};
    localparam logic [COLW-1:0]   CNT_ONE  = {{(COLW-1){1'b0}}, 1'b1};

    if (THRESH < 0) begin : g_thresh_check
        $error("sobel_kernel_block: THRESH must be non-negative");
    end

    // a + 2b + c, unsigned
    function automatic logic [SW-1:0] wsum3(input logic [PIXW-1:0] a,
                                            input logic [PIXW-1:0] b,
                                            input logic [PIXW-1:0] c);
        wsum3 = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // p - n as a signed value one bit wider than the sums
    function automatic logic signed [MW-1:0] sdiff(input logic [SW-1:0] p,
                                                   input logic [SW-1:0] n);
        sdiff = $signed({1'b0, p}) - $signed({1'b0, n});
    endfunction

    // Absolute value; the operands never reach the most negative code.
    function automatic logic [MW-1:0] absv(input logic signed [MW-1:0] v);
        if (v[MW-1]) begin
            absv = ~$unsigned(v) + {{(MW-1){1'b0}}, 1'b1};
        end else begin
            absv = $unsigned(v);
        end
    endfunction

    // Final output shaping: saturation, or binary edge flag when enabled.
    function automatic logic [OUTW-1:0] shape_mag(input logic [MW-1:0] m);
        logic [WW-1:0] w;
        w = WW'(m);
`ifdef SOBEL_THRESHOLD_EN
        if (int'(w) >= THRESH) begin
            shape_mag = {OUTW{1'b1}};
        end else begin
            shape_mag = {OUTW{1'b0}};
        end
`else
        if (w > WW'({OUTW{1'b1}})) begin
            shape_mag = {OUTW{1'b1}};
        end else begin
            shape_mag = w[OUTW-1:0];
        end
`endif
    endfunction

    // Row index: 0=A, 1=B, 2=C, 3=D
    col_t            up_s, lo_s;
    logic            produce_s;
    col_t            col_q, col_d;
    logic            primed_q, primed_d;
    logic            win_v_q, win_v_d;
    col_t            winl_q, winl_d, winm_q, winm_d, winr_q, winr_d;
    logic            s1_v_q, s1_v_d;
    logic [SW-1:0]   crb_q, crb_d, clb_q, clb_d, crc_q, crc_d, clc_q, clc_d;
    logic [3:0][SW-1:0] row_q, row_d;
    logic            s2_v_q, s2_v_d;
    logic signed [MW-1:0] gxb_q, gxb_d, gyb_q, gyb_d, gxc_q, gxc_d, gyc_q, gyc_d;
    logic [MW-1:0]   magb_s, magc_s;
    logic [OUTW-1:0] magb_q, magb_d, magc_q, magc_d;
    logic            magv_q, magv_d;
    logic [COLW-1:0] cnt_q, cnt_d;

    // Split each tap into its upper (column k+1) and lower (column k+2) pixel.
    always_comb begin
        up_s    = COL_ZERO;
        lo_s    = COL_ZERO;
        up_s[0] = sobelShiftOutA[2*PIXW-1:PIXW];
        up_s[1] = sobelShiftOutB[2*PIXW-1:PIXW];
        up_s[2] = sobelShiftOutC[2*PIXW-1:PIXW];
        up_s[3] = sobelShiftOutD[2*PIXW-1:PIXW];
        lo_s[0] = sobelShiftOutA[PIXW-1:0];
        lo_s[1] = sobelShiftOutB[PIXW-1:0];
        lo_s[2] = sobelShiftOutC[PIXW-1:0];
        lo_s[3] = sobelShiftOutD[PIXW-1:0];
    end

    // Priming, column register and window capture for productive beats.
    always_comb begin
        produce_s = sobelKernelEn & primed_q & ~lineStart;
        if (sobelKernelEn) begin
            col_d    = up_s;
            primed_d = 1'b1;
        end else begin
            col_d    = col_q;
            primed_d = primed_q;
        end
        win_v_d = produce_s;
        if (produce_s) begin
            winl_d = col_q;
            winm_d = up_s;
            winr_d = lo_s;
        end else begin
            winl_d = winl_q;
            winm_d = winm_q;
            winr_d = winr_q;
        end
    end

    // S1: weighted column sums (for Gx) and weighted row sums (for Gy).
    always_comb begin
        s1_v_d = win_v_q;
        crb_d  = wsum3(winr_q[0], winr_q[1], winr_q[2]);
        clb_d  = wsum3(winl_q[0], winl_q[1], winl_q[2]);
        crc_d  = wsum3(winr_q[1], winr_q[2], winr_q[3]);
        clc_d  = wsum3(winl_q[1], winl_q[2], winl_q[3]);
        row_d  = {(4*SW){1'b0}};
        for (int r = 0; r < 4; r++) begin
            row_d[r] = wsum3(winl_q[r], winm_q[r], winr_q[r]);
        end
    end

    // S2: signed gradients for both windows.
    always_comb begin
        s2_v_d = s1_v_q;
        gxb_d  = sdiff(crb_q, clb_q);
        gyb_d  = sdiff(row_q[2], row_q[0]);
        gxc_d  = sdiff(crc_q, clc_q);
        gyc_d  = sdiff(row_q[3], row_q[1]);
    end

    // S3: magnitude, output shaping; outputs hold while no result arrives.
    always_comb begin
        magb_s = absv(gxb_q) + absv(gyb_q);
        magc_s = absv(gxc_q) + absv(gyc_q);
        magv_d = s2_v_q;
        if (s2_v_q) begin
            magb_d = shape_mag(magb_s);
            magc_d = shape_mag(magc_s);
        end else begin
            magb_d = magb_q;
            magc_d = magc_q;
        end
    end

    // Column count: a lineStart beat clears it, beating a same-edge strobe.
    always_comb begin
        if (sobelKernelEn && lineStart) begin
            cnt_d = {COLW{1'b0}};
        end else if (s2_v_q) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State register for every stage; reset drops all in-flight results.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q    <= COL_ZERO;
            primed_q <= 1'b0;
            win_v_q  <= 1'b0;
            winl_q   <= COL_ZERO;
            winm_q   <= COL_ZERO;
            winr_q   <= COL_ZERO;
            s1_v_q   <= 1'b0;
            crb_q    <= {SW{1'b0}};
            clb_q    <= {SW{1'b0}};
            crc_q    <= {SW{1'b0}};
            clc_q    <= {SW{1'b0}};
            row_q    <= {(4*SW){1'b0}};
            s2_v_q   <= 1'b0;
            gxb_q    <= {MW{1'b0}};
            gyb_q    <= {MW{1'b0}};
            gxc_q    <= {MW{1'b0}};
            gyc_q    <= {MW{1'b0}};
            magb_q   <= {OUTW{1'b0}};
            magc_q   <= {OUTW{1'b0}};
            magv_q   <= 1'b0;
            cnt_q    <= {COLW{1'b0}};
        end else begin
            col_q    <= col_d;
            primed_q <= primed_d;
            win_v_q  <= win_v_d;
            winl_q   <= winl_d;
            winm_q   <= winm_d;
            winr_q   <= winr_d;
            s1_v_q   <= s1_v_d;
            crb_q    <= crb_d;
            clb_q    <= clb_d;
            crc_q    <= crc_d;
            clc_q    <= clc_d;
            row_q    <= row_d;
            s2_v_q   <= s2_v_d;
            gxb_q    <= gxb_d;
            gyb_q    <= gyb_d;
            gxc_q    <= gxc_d;
            gyc_q    <= gyc_d;
            magb_q   <= magb_d;
            magc_q   <= magc_d;
            magv_q   <= magv_d;
            cnt_q    <= cnt_d;
        end
    end

    assign magOutB  = magb_q;
    assign magOutC  = magc_q;
    assign magValid = magv_q;
    assign colCount = cnt_q;

endmodule

// File: tb/tb_sobel_kernel_block.sv
// Self-checking bench for sobel_kernel_block: directed lines from the test plan
// plus randomized traffic, compared every cycle against an integer window model.
module tb_sobel_kernel_block;

    localparam int PIXW   = 16;
    localparam int OUTW   = 16;
    localparam int COLW   = 12;
    localparam int THRESH = 1024;
    localparam int MAXOUT = 65535;
`ifdef SOBEL_THRESHOLD_EN
    localparam int EXP_V = 0, EXP_H = 0, EXP_SAT = 65535, EXP_255 = 0, EXP_256 = 65535;
`else
    localparam int EXP_V = 400, EXP_H = 200, EXP_SAT = 65535, EXP_255 = 1020, EXP_256 = 1024;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, en, ls;
    logic [31:0] ta, tb, tc, td;
    logic [15:0] mb, mc;
    logic        mv;
    logic [11:0] cc;

    sobel_kernel_block #(.PIXW(PIXW), .OUTW(OUTW), .COLW(COLW), .THRESH(THRESH)) dut (
        .clk(clk), .reset(reset), .sobelKernelEn(en), .lineStart(ls),
        .sobelShiftOutA(ta), .sobelShiftOutB(tb), .sobelShiftOutC(tc), .sobelShiftOutD(td),
        .magOutB(mb), .magOutC(mc), .magValid(mv), .colCount(cc)
    );

    typedef struct { int due; int b; int c; } res_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    res_t q[$];
    bit   primed  = 1'b0;
    int   prev[4];
    int   cnt     = 0;
    int   hold_b  = 0;
    int   hold_c  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // Gradient magnitude of the window centred on row r (1=B, 2=C), from pixel columns.
    function automatic int model_mag(input int lft[4], input int mid[4], input int rgt[4], input int r);
        int gx, gy, m;
        gx = (rgt[r-1] + 2*rgt[r] + rgt[r+1]) - (lft[r-1] + 2*lft[r] + lft[r+1]);
        gy = (lft[r+1] + 2*mid[r+1] + rgt[r+1]) - (lft[r-1] + 2*mid[r-1] + rgt[r-1]);
        m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > MAXOUT) m = MAXOUT;
`ifdef SOBEL_THRESHOLD_EN
        m = (m >= THRESH) ? MAXOUT : 0;
`endif
        return m;
    endfunction

    function automatic logic [31:0] rtap(input int mode);
        logic [31:0] v;
        if (mode == 0) v = $urandom;
        else           v = {8'h00, 8'($urandom_range(0, 255)), 8'h00, 8'($urandom_range(0, 255))};
        return v;
    endfunction

    // Drive one clock of inputs, advance the model for that edge, then check outputs.
    task automatic step(input bit rst, input bit e, input bit l,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
        int   up[4], lo[4];
        bit   v;
        res_t r;
        reset = rst; en = e; ls = l; ta = a; tb = b; tc = c; td = d;
        @(posedge clk);
        cyc++;
        up[0] = int'(a[31:16]); lo[0] = int'(a[15:0]);
        up[1] = int'(b[31:16]); lo[1] = int'(b[15:0]);
        up[2] = int'(c[31:16]); lo[2] = int'(c[15:0]);
        up[3] = int'(d[31:16]); lo[3] = int'(d[15:0]);
        v = 1'b0;
        if (rst) begin
            q.delete();
            primed = 1'b0; cnt = 0; hold_b = 0; hold_c = 0;
        end else begin
            v = (q.size() > 0) && (q[0].due == cyc);
            if (v) begin
                hold_b = q[0].b; hold_c = q[0].c;
                void'(q.pop_front());
            end
            if (e && l)  cnt = 0;
            else if (v)  cnt = (cnt + 1) % (1 << COLW);
            if (e) begin
                if (primed && !l) begin
                    r.due = cyc + 3;
                    r.b   = model_mag(prev, up, lo, 1);
                    r.c   = model_mag(prev, up, lo, 2);
                    q.push_back(r);
                end
                prev   = up;
                primed = 1'b1;
            end
        end
        #1;
        check_eq("magValid", 32'(mv), 32'(v));
        check_eq("colCount", 32'(cc), cnt);
        check_eq("magOutB",  32'(mb), hold_b);
        check_eq("magOutC",  32'(mc), hold_c);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'($urandom_range(0, 1)), rtap(0), rtap(0), rtap(0), rtap(0));
    endtask

    // lineStart beat, nb productive beats of constant taps, drain, then spot-check.
    task automatic run_line(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d,
                            input int nb, input int exp, input string tag);
        step(1'b0, 1'b1, 1'b1, a, b, c, d);
        repeat (nb) step(1'b0, 1'b1, 1'b0, a, b, c, d);
        repeat (4) idle();
        check_eq({tag, "_B"},   32'(mb), exp);
        check_eq({tag, "_C"},   32'(mc), exp);
        check_eq({tag, "_cnt"}, 32'(cc), nb);
    endtask

    initial begin
        // Reset, then flat image: 8 beats of 0x0100, first with lineStart.
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        run_line(32'h0100_0100, 32'h0100_0100, 32'h0100_0100, 32'h0100_0100, 7, 0, "flat");

        // Vertical step, horizontal step, saturation, threshold boundary steps.
        run_line(32'h0000_0064, 32'h0000_0064, 32'h0000_0064, 32'h0000_0064, 5, EXP_V, "vstep");
        run_line(32'h0000_0000, 32'h0000_0000, 32'h0032_0032, 32'h0032_0032, 5, EXP_H, "hstep");
        run_line(32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 4, EXP_SAT, "sat");
        run_line(32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF, 3, EXP_255, "step255");
        run_line(32'h0000_0100, 32'h0000_0100, 32'h0000_0100, 32'h0000_0100, 3, EXP_256, "step256");

        // Gapped productive beats with occasional mid-stream lineStart.
        step(1'b0, 1'b1, 1'b1, rtap(0), rtap(0), rtap(0), rtap(0));
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b1, 1'($urandom_range(0, 5) == 0), rtap(i % 2), rtap(0), rtap(1), rtap(0));
            repeat ($urandom_range(1, 3)) idle();
        end

        // lineStart beat on the same edge as an old-line strobe: the clear wins.
        repeat (3) step(1'b0, 1'b1, 1'b0, rtap(1), rtap(1), rtap(1), rtap(1));
        step(1'b0, 1'b1, 1'b1, rtap(1), rtap(1), rtap(1), rtap(1));
        repeat (3) step(1'b0, 1'b1, 1'b0, rtap(1), rtap(1), rtap(1), rtap(1));
        repeat (4) idle();

        // Reset with two results in flight: they must never appear.
        step(1'b0, 1'b1, 1'b1, rtap(0), rtap(0), rtap(0), rtap(0));
        repeat (2) step(1'b0, 1'b1, 1'b0, rtap(0), rtap(0), rtap(0), rtap(0));
        step(1'b1, 1'b1, 1'b0, rtap(0), rtap(0), rtap(0), rtap(0));
        repeat (5) idle();
        check_eq("rst_flight_cnt", 32'(cc), 0);

        // Column counter wrap: 4100 strobes on one line.
        step(1'b0, 1'b1, 1'b1, rtap(0), rtap(0), rtap(0), rtap(0));
        repeat (4100) step(1'b0, 1'b1, 1'b0, rtap(0), rtap(1), rtap(0), rtap(1));
        repeat (4) idle();
        check_eq("wrap_cnt", 32'(cc), 4);

        // Random mix of enables, lineStarts and rare resets.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 15) == 0),
                 rtap(i % 2), rtap(0), rtap(1), rtap(0));
        end
        repeat (4) idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
